// File: rtl/ir_receiver_bus_interface.sv
// IR receiver bus peripheral: decodes a pulse-width coded start burst plus command bits
// from an active-low IR envelope and exposes DATA/STATUS registers with a level interrupt.
module ir_receiver_bus_interface #(
    parameter logic [7:0]  BASE_ADDR = 8'hB4,
    parameter int unsigned PRESCALE  = 1000,
    parameter int unsigned DATA_BITS = 4,
    parameter int unsigned START_MIN = 150,
    parameter int unsigned START_MAX = 250,
    parameter int unsigned ZERO_MIN  = 20,
    parameter int unsigned ONE_MIN   = 70,
    parameter int unsigned BIT_MAX   = 120,
    parameter int unsigned GAP_MAX   = 100
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  logic [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    input  logic       IR_RX,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK
);

    localparam int unsigned PW          = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [7:0]  ADDR_STATUS = BASE_ADDR + 8'd1;
    localparam logic [15:0] C_START_MIN = 16'(START_MIN);
    localparam logic [15:0] C_START_MAX = 16'(START_MAX);
    localparam logic [15:0] C_ZERO_MIN  = 16'(ZERO_MIN);
    localparam logic [15:0] C_ONE_MIN   = 16'(ONE_MIN);
    localparam logic [15:0] C_BIT_MAX   = 16'(BIT_MAX);
    localparam logic [15:0] C_GAP_MAX   = 16'(GAP_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_GAP,
        S_BIT,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_ir_meta;
    logic                   r_ir_sync;
    logic                   r_burst_d;
    logic                   w_burst;
    logic                   w_rise;
    logic                   w_fall;
    logic [PW-1:0]          r_pre;
    logic [15:0]            r_cnt;
    logic                   w_tick;
    logic [DATA_BITS-1:0]   r_shift;
    logic [2:0]             r_bitcnt;
    logic [7:0]             r_data;
    logic                   r_valid;
    logic                   r_ovr;
    logic                   r_err;
    logic                   r_raise;
    logic                   r_rd_en;
    logic [7:0]             r_rd_data;
    logic                   w_clr_frame;
    logic                   w_shift;
    logic                   w_bit_val;
    logic                   w_bit_inc;
    logic                   w_set_err;
    logic                   w_done;
    logic                   w_status_wr;
    logic                   w_rd;
    logic [7:0]             w_status;

    // Synchroniser resets to the idle (no burst) level so reset release never fakes an edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ir_meta <= 1'b1;
            r_ir_sync <= 1'b1;
            r_burst_d <= 1'b0;
        end else begin
            r_ir_meta <= IR_RX;
            r_ir_sync <= r_ir_meta;
            r_burst_d <= ~r_ir_sync;
        end
    end

    assign w_burst = ~r_ir_sync;
    assign w_rise  = w_burst & ~r_burst_d;
    assign w_fall  = ~w_burst & r_burst_d;
    assign w_tick  = (r_pre == PW'(PRESCALE - 1));

    always_ff @(posedge CLK) begin
        if (RESET || w_rise || w_fall) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
            if (r_cnt != 16'hFFFF) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_clr_frame = 1'b0;
        w_shift     = 1'b0;
        w_bit_val   = 1'b0;
        w_bit_inc   = 1'b0;
        w_set_err   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                if (w_fall) begin
                    if (r_cnt >= C_START_MIN && r_cnt <= C_START_MAX) begin
                        w_clr_frame = 1'b1;
                        w_next      = S_GAP;
                    end else begin
                        w_next = S_IDLE;
                    end
                end else if (r_cnt > C_START_MAX) begin
                    w_next = S_IDLE;
                end
            end
            S_GAP: begin
                if (w_rise) begin
                    w_next = S_BIT;
                end else if (r_cnt > C_GAP_MAX) begin
                    w_set_err = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_BIT: begin
                if (w_fall) begin
                    if (r_cnt < C_ZERO_MIN || r_cnt > C_BIT_MAX) begin
                        w_set_err = 1'b1;
                        w_next    = S_IDLE;
                    end else begin
                        w_shift   = 1'b1;
                        w_bit_val = (r_cnt >= C_ONE_MIN);
                        if (r_bitcnt == 3'(DATA_BITS - 1)) begin
                            w_next = S_DONE;
                        end else begin
                            w_bit_inc = 1'b1;
                            w_next    = S_GAP;
                        end
                    end
                end else if (r_cnt > C_BIT_MAX) begin
                    w_set_err = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Shift via a widened concatenation so DATA_BITS = 1 needs no special slice.
    always_ff @(posedge CLK) begin
        if (RESET || w_clr_frame) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
        end else begin
            if (w_shift) begin
                r_shift <= DATA_BITS'({r_shift, w_bit_val});
            end
            if (w_bit_inc) begin
                r_bitcnt <= r_bitcnt + 3'd1;
            end
        end
    end

    assign w_status_wr = BUS_WE && (BUS_ADDR == ADDR_STATUS);
    assign w_rd        = !BUS_WE && (BUS_ADDR == BASE_ADDR || BUS_ADDR == ADDR_STATUS);
    assign w_status    = {5'b0, r_ovr, r_err, r_valid};

    // A completed frame and a new error both take priority over a same-cycle STATUS clear.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ovr     <= 1'b0;
            r_err     <= 1'b0;
            r_raise   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_data <= '0;
        end else begin
            if (w_done) begin
                r_data <= 8'(r_shift);
            end
            r_valid   <= w_done | (r_valid & ~w_status_wr);
            r_ovr     <= (w_done & r_valid) | (r_ovr & ~w_status_wr);
            r_err     <= w_set_err | (r_err & ~w_status_wr);
            r_raise   <= w_done | (r_raise & ~BUS_INTERRUPT_ACK);
            r_rd_en   <= w_rd;
            r_rd_data <= (BUS_ADDR == BASE_ADDR) ? r_data : w_status;
        end
    end

    assign BUS_INTERRUPT_RAISE = r_raise;
    assign BUS_DATA            = r_rd_en ? r_rd_data : 'z;

endmodule

// File: tb/tb_ir_receiver_bus_interface.sv
// Self-checking bench for ir_receiver_bus_interface: frame-level reference model plus
// per-cycle comparison of RAISE and BUS_DATA, with literal checks at key points.
module tb_ir_receiver_bus_interface;

    localparam int         P       = 10;
    localparam int         NB      = 4;
    localparam int         ONE_MIN = 70;
    localparam logic [7:0] BASE    = 8'hB4;
    localparam logic [7:0] STAT    = 8'hB5;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       we   = 1'b0;
    logic       ir   = 1'b1;
    logic       ack  = 1'b0;
    logic [7:0] addr = 8'h00;
    logic       raise;
    wire  [7:0] bus_data;

    // Undriven bus floats to 8'hFF; decoded registers never reach that value.
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (bus_data[g]);
    end

    ir_receiver_bus_interface #(.PRESCALE(P)) u_dut (
        .CLK                 (clk),
        .RESET               (rst),
        .BUS_DATA            (bus_data),
        .BUS_ADDR            (addr),
        .BUS_WE              (we),
        .IR_RX               (ir),
        .BUS_INTERRUPT_RAISE (raise),
        .BUS_INTERRUPT_ACK   (ack)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic       m_raise = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ovr   = 1'b0;
    logic       m_err   = 1'b0;
    logic       m_drv   = 1'b0;
    logic [7:0] m_bus   = 8'h00;
    int         done_at = -1;
    logic [7:0] done_val = 8'h00;
    logic       pend_err = 1'b0;

    int g_gap[NB];
    int g_bit[NB];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Register-level rules of the peripheral, driven by frame outcomes the stimulus decides.
    always @(posedge clk) begin
        logic [7:0] status_before;
        logic       valid_before;
        logic       done_now;
        logic       clear_now;
        cyc++;
        status_before = {5'b0, m_ovr, m_err, m_valid};
        valid_before  = m_valid;
        if (rst) begin
            m_raise = 0; m_data = 0; m_valid = 0; m_ovr = 0; m_err = 0; m_drv = 0;
            done_at = -1; pend_err = 0;
        end else begin
            m_drv     = !we && (addr == BASE || addr == STAT);
            m_bus     = (addr == BASE) ? m_data : status_before;
            done_now  = (cyc == done_at);
            clear_now = we && (addr == STAT);
            if (clear_now) begin
                m_valid = 0; m_ovr = 0; m_err = 0;
            end
            if (done_now) begin
                m_data  = done_val;
                m_valid = 1;
                if (valid_before) m_ovr = 1;
                m_raise = 1;
            end else if (ack) begin
                m_raise = 0;
            end
            if (pend_err) m_err = 1;
            pend_err = 0;
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("raise", {7'b0, raise}, {7'b0, m_raise});
            chk("bus", bus_data, m_drv ? m_bus : 8'hFF);
        end
    end

    task automatic hold(input logic v, input int ticks);
        ir = v;
        repeat (ticks * P) @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [7:0] a, input logic [7:0] exp, input string name);
        @(posedge clk); #1; we = 0; addr = a;
        @(posedge clk); #1; addr = 8'h00;
        @(negedge clk); chk(name, bus_data, exp);
        @(negedge clk); chk({name, "_released"}, bus_data, 8'hFF);
        @(posedge clk); #1;
    endtask

    task automatic bus_write(input logic [7:0] a);
        @(posedge clk); #1; we = 1; addr = a;
        @(posedge clk); #1; we = 0; addr = 8'h00;
    endtask

    task automatic do_ack();
        @(posedge clk); #1; ack = 1;
        @(posedge clk); #1; ack = 0;
        @(negedge clk); chk("raise_after_ack", {7'b0, raise}, 8'h00);
        @(posedge clk); #1;
    endtask

    // Bits are MSB first; a burst of at least ONE_MIN ticks is a 1.
    task automatic send_frame(input int start_t, input bit co_wr, input bit co_ack);
        logic [7:0] v;
        v = 8'h00;
        hold(0, start_t);
        for (int i = 0; i < NB; i++) begin
            hold(1, g_gap[i]);
            hold(0, g_bit[i]);
            v = {v[6:0], (g_bit[i] >= ONE_MIN)};
        end
        ir       = 1;
        done_val = v;
        done_at  = cyc + 4;
        if (co_wr || co_ack) begin
            repeat (3) @(posedge clk);
            #1; we = co_wr; addr = co_wr ? STAT : 8'h00; ack = co_ack;
            @(posedge clk);
            #1; we = 0; addr = 8'h00; ack = 0;
        end
        hold(1, 20);
    endtask

    task automatic frame_val(input logic [3:0] v, input bit co_wr, input bit co_ack);
        for (int i = 0; i < NB; i++) begin
            g_gap[i] = 50;
            g_bit[i] = v[NB-1-i] ? 90 : 30;
        end
        send_frame(200, co_wr, co_ack);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (5) @(posedge clk);
        #1; rst = 0;
        @(negedge clk); chk("reset_raise", {7'b0, raise}, 8'h00);
        chk("reset_bus", bus_data, 8'hFF);
        bus_read(BASE, 8'h00, "reset_data");
        bus_read(STAT, 8'h00, "reset_status");

        // Nominal frame 1011
        g_gap = '{50, 50, 50, 50};
        g_bit = '{90, 30, 90, 90};
        send_frame(200, 0, 0);
        chk("nominal_raise", {7'b0, raise}, 8'h01);
        bus_read(BASE, 8'h0B, "nominal_data");
        bus_read(STAT, 8'h01, "nominal_status");
        bus_read(8'h10, 8'hFF, "unrelated_read");
        do_ack();
        bus_write(STAT);
        bus_read(STAT, 8'h00, "clear_status");

        // Short start then over-long start: both silently rejected
        hold(0, 100); hold(1, 50); hold(0, 300); hold(1, 30);
        bus_read(STAT, 8'h00, "noise_status");
        chk("noise_raise", {7'b0, raise}, 8'h00);

        // Gap timeout
        hold(0, 200); hold(1, 150);
        pend_err = 1;
        bus_read(STAT, 8'h02, "gap_err_status");
        bus_write(STAT);
        hold(0, 200); hold(1, 50); hold(0, 10); hold(1, 30);
        pend_err = 1;
        bus_read(STAT, 8'h02, "short_bit_status");
        bus_write(STAT);
        bus_read(STAT, 8'h00, "err_cleared");

        // Overrun: 0101 then 1010 without clearing
        frame_val(4'h5, 0, 0);
        frame_val(4'hA, 0, 0);
        bus_read(BASE, 8'h0A, "overrun_data");
        bus_read(STAT, 8'h05, "overrun_status");

        // DONE coincident with STATUS write and with ACK
        frame_val(4'h9, 1, 1);
        chk("coincide_raise", {7'b0, raise}, 8'h01);
        bus_read(STAT, 8'h05, "coincide_status");
        bus_read(BASE, 8'h09, "coincide_data");

        // Reset after the second data bit
        hold(0, 200); hold(1, 50); hold(0, 90); hold(1, 50); hold(0, 30);
        ir = 1; rst = 1;
        repeat (3) @(posedge clk);
        #1; rst = 0;
        @(negedge clk); chk("midreset_raise", {7'b0, raise}, 8'h00);
        bus_read(STAT, 8'h00, "midreset_status");
        bus_read(BASE, 8'h00, "midreset_data");
        hold(1, 60);
        frame_val(4'h6, 0, 0);
        bus_read(BASE, 8'h06, "after_reset_data");
        bus_read(STAT, 8'h01, "after_reset_status");
        do_ack();

        // Randomised frames with random bus traffic between them
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NB; i++) begin
                g_gap[i] = int'($urandom_range(50, 25));
                g_bit[i] = ($urandom_range(1, 0) == 1) ? int'($urandom_range(100, 75))
                                                       : int'($urandom_range(50, 25));
            end
            send_frame(int'($urandom_range(200, 160)), $urandom_range(3, 0) == 0,
                       $urandom_range(3, 0) == 0);
            for (int k = 0; k < 6; k++) begin
                case ($urandom_range(4, 0))
                    0: begin
                        @(posedge clk); #1; we = 0; addr = BASE;
                        @(posedge clk); #1; addr = 8'h00;
                    end
                    1: begin
                        @(posedge clk); #1; we = 0; addr = STAT;
                        @(posedge clk); #1; addr = 8'h00;
                    end
                    2: bus_write(($urandom_range(1, 0) == 1) ? STAT : BASE);
                    3: begin
                        @(posedge clk); #1; ack = 1;
                        @(posedge clk); #1; ack = 0;
                    end
                    default: begin
                        @(posedge clk); #1; we = 0; addr = 8'($urandom_range(255, 0));
                        @(posedge clk); #1; addr = 8'h00;
                    end
                endcase
                repeat ($urandom_range(3, 0)) @(posedge clk);
                #1;
            end
        end
        repeat (4) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ir_receiver_bus_interface.md
Name: ir_receiver_bus_interface

Overview:
- Memory-mapped IR receiver peripheral on the shared 8-bit processor bus. It is the receive end of the IR car-command link.
- Decodes the demodulated envelope from an IR detector into a start burst plus DATA_BITS command bits. Bursts are pulse-width coded.
- Latches each decoded frame into a bus-readable register and raises a level interrupt that is held until the processor acknowledges it.

Parameters:
- BASE_ADDR, 8'hB4: bus base address. BASE+0 is DATA, BASE+1 is STATUS.
- PRESCALE, 1000: CLK cycles per timing tick (10 us at 100 MHz).
- DATA_BITS, 4: command bits per frame, MSB first. Legal range 1..8.
- START_MIN, 150: minimum start-burst length, in ticks.
- START_MAX, 250: maximum start-burst length, in ticks.
- ZERO_MIN, 20: minimum data-burst length, in ticks.
- ONE_MIN, 70: data-burst length at or above which the bit decodes as 1, in ticks.
- BIT_MAX, 120: maximum data-burst length, in ticks.
- GAP_MAX, 100: maximum inter-burst gap, in ticks.

Ports:
- CLK, input, 1: system clock.
- RESET, input, 1: synchronous, active-high reset.
- BUS_DATA, inout, 8: shared bus data. Driven only during this block's read slot, otherwise high-Z.
- BUS_ADDR, input, 8: bus address.
- BUS_WE, input, 1: bus write enable. 1 = write, 0 = read.
- IR_RX, input, 1: demodulated IR envelope, asynchronous, active-low (0 = burst present).
- BUS_INTERRUPT_RAISE, output, 1: frame-received interrupt, level.
- BUS_INTERRUPT_ACK, input, 1: one-cycle acknowledge from the processor.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high (CLK, RESET).
- Reset values:
  - BUS_INTERRUPT_RAISE = 0; BUS_DATA = high-Z.
  - DATA = 0; STATUS flags = 0.
  - FSM = IDLE; prescaler, tick counter and bit counter = 0.
- Input path:
  - IR_RX passes through a 2-FF synchroniser and is inverted to give burst (1 = carrier present).
  - Edges are detected on the synchronised signal.
  - Total input latency is 3 CLK before the FSM sees an edge.
- Timing:
  - The prescaler wraps at PRESCALE-1 and emits a 1-cycle tick.
  - The 16-bit duration counter increments on each tick and saturates at 16'hFFFF.
  - The counter and prescaler clear on every synchronised edge.
- FSM:
  - IDLE: a burst rising edge goes to START.
  - START, on burst falling edge: if START_MIN <= count <= START_MAX, clear the shift register and bit counter and go to GAP. Otherwise go to IDLE with no flag change (noise reject).
  - START, if count exceeds START_MAX while the burst is still high: go to IDLE.
  - GAP: a burst rising edge goes to BIT.
  - GAP, if count > GAP_MAX: set ERR and go to IDLE.
  - BIT, on falling edge, classify the burst length:
    - count < ZERO_MIN or count > BIT_MAX: set ERR, go to IDLE.
    - count >= ONE_MIN: shift in 1.
    - otherwise: shift in 0.
    - After the shift, if bit counter = DATA_BITS-1 go to DONE, else increment the bit counter and go to GAP.
  - BIT, if count > BIT_MAX while the burst is still high: set ERR and go to IDLE. No shift occurs.
  - DONE, single cycle:
    - DATA <= zero-extended shift register.
    - If VALID was already 1, set OVR.
    - Set VALID and BUS_INTERRUPT_RAISE.
    - Go to IDLE.
- Registers:
  - DATA (BASE+0) is read-only.
  - STATUS (BASE+1), read: {5'b0, OVR, ERR, VALID}.
  - Any bus write to BASE+1 clears VALID, OVR and ERR. Write data is ignored.
  - Writes to BASE+0 are ignored.
- Read timing:
  - A read is BUS_ADDR in {BASE, BASE+1} with BUS_WE = 0 in cycle N.
  - In cycle N+1 the block drives the registered read value on BUS_DATA.
  - BUS_DATA is high-Z in every other cycle.
  - A read of DATA does not clear VALID.
- Interrupt:
  - RAISE is set in DONE and cleared on the cycle after ACK = 1.
  - If ACK = 1 and DONE occur in the same cycle, RAISE stays 1.
- Simultaneous events:
  - DONE and a STATUS write in the same cycle: DONE wins. VALID = 1; OVR is computed from the pre-write VALID.
  - ERR set and a STATUS write in the same cycle: ERR = 1.
- Reset mid-frame: the FSM returns to IDLE on the next edge. The partial frame is discarded and no interrupt is raised.
- The decoder is not blocked by an unacknowledged interrupt. New frames overwrite DATA.

Test Plan:
- Bench setup for all scenarios: PRESCALE=10, default thresholds, DATA_BITS=4.
- Nominal frame: start burst of 200 ticks; gaps of 50 ticks; bursts of 90/30/90/90 ticks. Expected: RAISE rises 1 cycle after the last falling edge is seen; a DATA read returns 8'h0B; a STATUS read returns 8'h01; ACK drops RAISE on the next cycle.
- Noise rejection: start burst of 100 ticks, then a burst of 300 ticks. Expected: FSM returns to IDLE; STATUS stays 8'h00; RAISE stays 0.
- Error paths:
  - Valid start, then a gap of 150 ticks: STATUS = 8'h02.
  - Write to BASE+1, then a valid start and a 10-tick data burst: STATUS = 8'h02.
  - A write to BASE+1 clears STATUS to 8'h00.
- Overrun: two valid frames, 8'h05 then 8'h0A, with no STATUS clear between them. Expected: DATA = 8'h0A; STATUS = 8'h05.
- Bus protocol:
  - A read of an unrelated address leaves BUS_DATA high-Z.
  - A read of BASE drives BUS_DATA only in cycle N+1.
  - Same-cycle DONE and STATUS write leaves VALID = 1.
  - Same-cycle ACK and DONE leaves RAISE = 1.
- Reset mid-frame: assert RESET after the second data bit. Expected: all outputs return to their reset values. A following full frame of 8'h06 decodes correctly.
